ahb2apb_bridge_mslv: RTL and testbench
======================================

// Module: ahb2apb_bridge_mslv
// PURPOSE
//  Parametrised AHB-Lite slave to APB3 master bridge. It drives NUM_SLV APB slaves, each in a
//  fixed 2^SLV_ADDR_BITS byte window above BASE_ADDR. It supports PREADY wait states and
//  PSLVERR, answers unmapped addresses with the AHB two-cycle ERROR response, and times out
//  hung slaves. It sits between the AHB interconnect and the GPIO/peripheral APB segment.
// PARAMETERS
//  ADDR_W        32          address width (AHB and APB)
//  DATA_W        32          data width
//  NUM_SLV       4           number of APB slaves, 1..16
//  SLV_ADDR_BITS 15          log2 of the window size per slave (32 KB)
//  BASE_ADDR     32'h0       base of slave 0; slave k at BASE_ADDR + k<<SLV_ADDR_BITS
//  TIMEOUT_CYC   256         max ACCESS cycles with PREADY low before abort; 0 = disabled
// PORTS
//  iHCLK      in   1               clock, all logic on rising edge
//  iHRESETn   in   1               asynchronous active-low reset
//  iHSEL      in   1               bridge selected
//  iHTRANS    in   2               IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  iHWRITE    in   1               1 = write
//  iHADDR     in   ADDR_W          address (address phase)
//  iHWDATA    in   DATA_W          write data (data phase)
//  iHREADY    in   1               bus HREADY (previous transfer done)
//  oHREADYOUT out  1               bridge ready
//  oHRESP     out  2               OKAY=00 ERROR=01
//  oHRDATA    out  DATA_W          read data
//  iPRDATA    in   NUM_SLV*DATA_W  per-slave read data, slave k at [k*DATA_W +: DATA_W]
//  iPREADY    in   NUM_SLV         per-slave ready
//  iPSLVERR   in   NUM_SLV         per-slave error
//  oPSEL      out  NUM_SLV         one-hot slave select
//  oPENABLE   out  1               APB access phase
//  oPWRITE    out  1               APB direction
//  oPADDR     out  ADDR_W          APB address, full AHB address registered
//  oPWDATA    out  DATA_W          APB write data, registered
// BEHAVIOUR
//  - Reset (async): state IDLE. oHREADYOUT=1, oHRESP=OKAY, oPSEL=0, oPENABLE=0, oPWRITE=0,
//    oPADDR=0, oPWDATA=0, oHRDATA=0, timeout counter=0.
//  - accept = iHSEL & iHREADY & iHTRANS[1]. BUSY/IDLE transfers give a zero-wait OKAY and are
//    otherwise ignored. On accept: latch iHADDR, iHWRITE and the slave index
//    (iHADDR-BASE_ADDR)>>SLV_ADDR_BITS.
//  - Decode miss: address < BASE_ADDR, or index >= NUM_SLV. No APB cycle; go to ERR1.
//  - States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
//    IDLE  : accept & hit & write -> WDATA; accept & hit & read -> SETUP; accept & miss -> ERR1.
//    WDATA : latch iHWDATA into oPWDATA -> SETUP. oHREADYOUT=0.
//    SETUP : oPSEL[idx]=1, oPENABLE=0, oHREADYOUT=0 -> ACCESS.
//    ACCESS: oPSEL[idx]=1, oPENABLE=1.
//      PREADY=0: stay, oHREADYOUT=0, counter++.
//      PREADY=1 & !PSLVERR: oHREADYOUT=1, OKAY, oHRDATA=iPRDATA[idx] (combinational).
//        Next state follows the IDLE rules using this cycle's accept (back-to-back, no idle gap).
//      PREADY=1 & PSLVERR, or counter reaches TIMEOUT_CYC-1 with PREADY=0: -> ERR1.
//    ERR1  : oHRESP=ERROR, oHREADYOUT=0, oPSEL=0, oPENABLE=0 -> ERR2.
//    ERR2  : oHRESP=ERROR, oHREADYOUT=1. Next state follows the IDLE rules (accept honoured).
//  - oPSEL and oPENABLE are 0 in IDLE, WDATA, ERR1 and ERR2. oPADDR, oPWRITE and oPWDATA are held
//    stable from SETUP through ACCESS completion.
//  - The counter clears on entry to SETUP.
//  - oHRDATA is 0 outside read completion. oHRESP is OKAY outside ERR1/ERR2.
//  - Latency, zero-wait slave: read = 2 data-phase cycles (1 wait), write = 3 (2 waits).
//    Each PREADY-low cycle adds 1.
//  - Reset asserted mid-transfer: immediate return to reset values. The APB cycle is dropped
//    and PSEL is never left asserted.
// TESTING
//  - Read 0x0000_8004 (slave 1), PREADY=1, PRDATA1=0xA5A5_0001 -> PSEL=0010, 1 wait state,
//    HRDATA=0xA5A5_0001, OKAY.
//  - Write 0x0001_0000 data 0x1234_5678 to slave 2, PREADY low 3 cycles -> PWDATA=0x12345678
//    stable throughout, 5 HREADYOUT-low cycles.
//  - Read 0x0002_0000 (index 4, NUM_SLV=4) -> no PSEL, ERR1 then ERR2 (ERROR with HREADYOUT
//    0 then 1).
//  - Slave 0 returns PSLVERR=1 with PREADY=1 -> two-cycle ERROR; the next queued NONSEQ in ERR2
//    starts SETUP directly.
//  - TIMEOUT_CYC=4, PREADY stuck at 0 -> abort after 4 ACCESS cycles, ERROR, PSEL=0.
//  - Four back-to-back NONSEQ reads across slaves 0..3 -> no IDLE state between them.
//    Assert iHRESETn low during ACCESS -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ahb2apb_bridge_mslv_if.sv
// Bus bundle for the AHB-Lite to APB3 bridge: AHB slave side plus the APB master side.
// The "slave" modport is the bridge's view; "master" is the surrounding system's view.
interface ahb2apb_bridge_mslv_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                      iHSEL;
  logic [1:0]                iHTRANS;
  logic                      iHWRITE;
  logic [ADDR_W-1:0]         iHADDR;
  logic [DATA_W-1:0]         iHWDATA;
  logic                      iHREADY;
  logic                      oHREADYOUT;
  logic [1:0]                oHRESP;
  logic [DATA_W-1:0]         oHRDATA;
  logic [NUM_SLV*DATA_W-1:0] iPRDATA;
  logic [NUM_SLV-1:0]        iPREADY;
  logic [NUM_SLV-1:0]        iPSLVERR;
  logic [NUM_SLV-1:0]        oPSEL;
  logic                      oPENABLE;
  logic                      oPWRITE;
  logic [ADDR_W-1:0]         oPADDR;
  logic [DATA_W-1:0]         oPWDATA;

  modport slave (
    input  iHSEL, iHTRANS, iHWRITE, iHADDR, iHWDATA, iHREADY,
    input  iPRDATA, iPREADY, iPSLVERR,
    output oHREADYOUT, oHRESP, oHRDATA,
    output oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA
  );

  modport master (
    output iHSEL, iHTRANS, iHWRITE, iHADDR, iHWDATA, iHREADY,
    output iPRDATA, iPREADY, iPSLVERR,
    input  oHREADYOUT, oHRESP, oHRDATA,
    input  oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA
  );
endinterface

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite slave to APB3 master bridge with address decode to NUM_SLV windows,
// PREADY wait states, PSLVERR / decode-miss / timeout mapped to the two-cycle AHB ERROR.
module ahb2apb_bridge_mslv #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLV       = 4,
  parameter int                SLV_ADDR_BITS = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = {ADDR_W{1'b0}},
  parameter int                TIMEOUT_CYC   = 256
) (
  input  logic                  iHCLK,
  input  logic                  iHRESETn,
  ahb2apb_bridge_mslv_if.slave  bus
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  state_e              state_q, state_d, entry_s;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept_s, hit_s, timeout_s, take_s;
  logic [ADDR_W-1:0]   offset_s, idx_full_s;
  logic [IDX_W-1:0]    idx_s;
  logic                sel_ready_s, sel_err_s;
  logic [DATA_W-1:0]   sel_rdata_s;
  logic                hreadyout_s, penable_s;
  logic [1:0]          hresp_s;
  logic [NUM_SLV-1:0]  psel_s;
  logic [DATA_W-1:0]   hrdata_s;

  assign accept_s = bus.iHSEL & bus.iHREADY & bus.iHTRANS[1];

  // Address decode of the current AHB address phase.
  always_comb begin
    offset_s   = bus.iHADDR - BASE_ADDR;
    idx_full_s = offset_s >> SLV_ADDR_BITS;
    hit_s      = (bus.iHADDR >= BASE_ADDR) && (idx_full_s < ADDR_W'(NUM_SLV));
    idx_s      = idx_full_s[IDX_W-1:0];
  end

  // Response signals of the slave selected by the latched index.
  always_comb begin
    sel_ready_s = bus.iPREADY[idx_q];
    sel_err_s   = bus.iPSLVERR[idx_q];
    sel_rdata_s = bus.iPRDATA[idx_q*DATA_W +: DATA_W];
  end

  // Hung-slave detection; a zero TIMEOUT_CYC disables it.
  always_comb begin
    if (TIMEOUT_CYC == 0) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

  // Where a newly offered transfer leads; shared by IDLE, ACCESS completion and ERR2.
  always_comb begin
    if (!accept_s) begin
      entry_s = ST_IDLE;
    end else if (!hit_s) begin
      entry_s = ST_ERR1;
    end else if (bus.iHWRITE) begin
      entry_s = ST_WDATA;
    end else begin
      entry_s = ST_SETUP;
    end
  end

  // State register.
  always_ff @(posedge iHCLK or negedge iHRESETn) begin
    if (!iHRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = entry_s;
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready_s) begin
          state_d = sel_err_s ? ST_ERR1 : entry_s;
        end else if (timeout_s) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = entry_s;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic; HRDATA is passed straight through on a good read completion.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = RESP_OKAY;
    psel_s      = {NUM_SLV{1'b0}};
    penable_s   = 1'b0;
    hrdata_s    = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE:   hreadyout_s = 1'b1;
      ST_WDATA:  hreadyout_s = 1'b0;
      ST_SETUP: begin
        hreadyout_s = 1'b0;
        psel_s      = NUM_SLV'(1'b1) << idx_q;
      end
      ST_ACCESS: begin
        psel_s    = NUM_SLV'(1'b1) << idx_q;
        penable_s = 1'b1;
        if (sel_ready_s && !sel_err_s) begin
          hreadyout_s = 1'b1;
          hrdata_s    = write_q ? {DATA_W{1'b0}} : sel_rdata_s;
        end else begin
          hreadyout_s = 1'b0;
        end
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = RESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = RESP_ERROR;
      end
      default:   hreadyout_s = 1'b1;
    endcase
    take_s = accept_s & hreadyout_s;
  end

  // Address-phase capture; holds the APB address/direction until the next accepted transfer.
  always_ff @(posedge iHCLK or negedge iHRESETn) begin
    if (!iHRESETn) begin
      addr_q  <= {ADDR_W{1'b0}};
      write_q <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
    end else if (take_s) begin
      addr_q  <= bus.iHADDR;
      write_q <= bus.iHWRITE;
      idx_q   <= idx_s;
    end
  end

  // Write data capture during the AHB data phase.
  always_ff @(posedge iHCLK or negedge iHRESETn) begin
    if (!iHRESETn) begin
      pwdata_q <= {DATA_W{1'b0}};
    end else if (state_q == ST_WDATA) begin
      pwdata_q <= bus.iHWDATA;
    end
  end

  // Wait-state counter, cleared on entry to SETUP.
  always_ff @(posedge iHCLK or negedge iHRESETn) begin
    if (!iHRESETn) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if ((state_q == ST_ACCESS) && !sel_ready_s) begin
      cnt_q <= cnt_q + CNT_W'(1'b1);
    end
  end

  assign bus.oHREADYOUT = hreadyout_s;
  assign bus.oHRESP     = hresp_s;
  assign bus.oHRDATA    = hrdata_s;
  assign bus.oPSEL      = psel_s;
  assign bus.oPENABLE   = penable_s;
  assign bus.oPWRITE    = write_q;
  assign bus.oPADDR     = addr_q;
  assign bus.oPWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Bench for ahb2apb_bridge_mslv: pipelined AHB driver, emulated APB slaves with programmable
// wait/error, and a transaction-level model predicting latency, response and read data.
module tb_ahb2apb_bridge_mslv;
  localparam int NS = 4;
  localparam int TO = 4;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [1:0]  trans;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb2apb_bridge_mslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NS)) bus ();

  ahb2apb_bridge_mslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .SLV_ADDR_BITS(15),
    .BASE_ADDR(32'h0), .TIMEOUT_CYC(TO)
  ) dut (
    .iHCLK(clk),
    .iHRESETn(rst_n),
    .bus(bus)
  );

  int          errors = 0;
  int          checks = 0;
  txn_t        seq_q[$];
  logic [31:0] ref_mem [NS];
  logic [31:0] apb_mem [NS];
  int          cfg_wait = 0;
  bit          cfg_err = 1'b0;
  int          acc_cnt;
  logic        ready_now;

  // APB slave emulation: ready after cfg_wait low ACCESS cycles, unselected slaves flag errors.
  assign bus.iHREADY  = bus.oHREADYOUT;
  assign ready_now    = bus.oPENABLE && (acc_cnt >= cfg_wait);
  assign bus.iPREADY  = ready_now ? bus.oPSEL : 4'b0000;
  assign bus.iPSLVERR = (cfg_err ? bus.iPREADY : 4'b0000) | ~bus.oPSEL;
  for (genvar g = 0; g < NS; g++) begin : g_prdata
    assign bus.iPRDATA[g*32 +: 32] = apb_mem[g];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (bus.oPENABLE && !ready_now) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) apb_mem[k] <= 32'hA5A5_0000 + 32'(k);
    end else if (ready_now && bus.oPWRITE && !cfg_err) begin
      for (int k = 0; k < NS; k++) if (bus.oPSEL[k]) apb_mem[k] <= bus.oPWDATA;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic txn_t mk(input logic [31:0] a, input bit w, input logic [31:0] d,
                              input int wt, input bit e);
    txn_t t;
    t.addr = a; t.wr = w; t.wdata = d; t.waits = wt; t.err = e; t.trans = 2'b10;
    return t;
  endfunction

  task automatic idle_bus();
    bus.iHSEL = 1'b0; bus.iHTRANS = 2'b00; bus.iHWRITE = 1'b0; bus.iHADDR = 32'h0;
  endtask

  task automatic present(input int i);
    bus.iHSEL = 1'b1; bus.iHTRANS = seq_q[i].trans;
    bus.iHWRITE = seq_q[i].wr; bus.iHADDR = seq_q[i].addr;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_bus();
    bus.iHWDATA = 32'h0; cfg_wait = 0; cfg_err = 1'b0;
    for (int k = 0; k < NS; k++) ref_mem[k] = 32'hA5A5_0000 + 32'(k);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string name);
    checks++; if (bus.oHREADYOUT !== 1'b1) begin errors++; $display("FAIL %s hreadyout got=%b exp=1", name, bus.oHREADYOUT); end
    checks++; if (bus.oHRESP !== 2'b00) begin errors++; $display("FAIL %s hresp got=%b exp=00", name, bus.oHRESP); end
    checks++; if (bus.oPSEL !== 4'b0000) begin errors++; $display("FAIL %s psel got=%b exp=0000", name, bus.oPSEL); end
    checks++; if (bus.oPENABLE !== 1'b0) begin errors++; $display("FAIL %s penable got=%b exp=0", name, bus.oPENABLE); end
    checks++; if (bus.oPWRITE !== 1'b0) begin errors++; $display("FAIL %s pwrite got=%b exp=0", name, bus.oPWRITE); end
    checks++; if (bus.oPADDR !== 32'h0) begin errors++; $display("FAIL %s paddr got=%h exp=0", name, bus.oPADDR); end
    checks++; if (bus.oPWDATA !== 32'h0) begin errors++; $display("FAIL %s pwdata got=%h exp=0", name, bus.oPWDATA); end
    checks++; if (bus.oHRDATA !== 32'h0) begin errors++; $display("FAIL %s hrdata got=%h exp=0", name, bus.oHRDATA); end
  endtask

  // Runs seq_q as a pipelined AHB burst and checks each transfer against the model.
  task automatic run_seq(input string name);
    int n, ai, ap, di, done, guard, dcyc, pcyc, ecyc, rcyc, idx, acc, xcyc;
    bit ap_v, hit, xerr, hro, prev_hro;
    logic [1:0] resp, prev_resp;
    logic [3:0] xsel;
    logic [31:0] xrd;
    txn_t t;
    n = seq_q.size(); di = -1; done = 0; guard = 0;
    dcyc = 0; pcyc = 0; ecyc = 0; rcyc = 0; idx = 0; acc = 0; xcyc = 0;
    hit = 1'b0; xerr = 1'b0; xsel = 4'b0; prev_hro = 1'b1; prev_resp = 2'b00;
    @(posedge clk); #1;
    present(0); ap = 0; ap_v = 1'b1; ai = 1;
    while (done < n && guard < 400) begin
      @(negedge clk);
      guard++;
      hro = bus.oHREADYOUT; resp = bus.oHRESP;
      if (di >= 0) begin
        dcyc++;
        if (bus.oPSEL !== 4'b0000) begin
          pcyc++;
          checks++; if (bus.oPSEL !== xsel) begin errors++; $display("FAIL %s[%0d] psel got=%b exp=%b", name, di, bus.oPSEL, xsel); end
          checks++; if (bus.oPADDR !== t.addr) begin errors++; $display("FAIL %s[%0d] paddr got=%h exp=%h", name, di, bus.oPADDR, t.addr); end
          checks++; if (bus.oPWRITE !== t.wr) begin errors++; $display("FAIL %s[%0d] pwrite got=%b exp=%b", name, di, bus.oPWRITE, t.wr); end
          if (t.wr) begin
            checks++; if (bus.oPWDATA !== t.wdata) begin errors++; $display("FAIL %s[%0d] pwdata got=%h exp=%h", name, di, bus.oPWDATA, t.wdata); end
          end
        end else begin
          checks++; if (bus.oPENABLE !== 1'b0) begin errors++; $display("FAIL %s[%0d] penable without psel got=%b exp=0", name, di, bus.oPENABLE); end
        end
        if (bus.oPENABLE === 1'b1) ecyc++;
        if (resp === 2'b01) rcyc++;
        if (!hro) begin
          checks++; if (bus.oHRDATA !== 32'h0) begin errors++; $display("FAIL %s[%0d] hrdata while waiting got=%h exp=0", name, di, bus.oHRDATA); end
        end
      end
      if (hro) begin
        if (di >= 0) begin
          xrd = (hit && !xerr && !t.wr) ? ref_mem[idx] : 32'h0;
          checks++; if (dcyc != xcyc) begin errors++; $display("FAIL %s[%0d] data-phase cycles got=%0d exp=%0d", name, di, dcyc, xcyc); end
          checks++; if (resp !== (xerr ? 2'b01 : 2'b00)) begin errors++; $display("FAIL %s[%0d] hresp got=%b exp=%b", name, di, resp, xerr ? 2'b01 : 2'b00); end
          checks++; if (bus.oHRDATA !== xrd) begin errors++; $display("FAIL %s[%0d] hrdata got=%h exp=%h", name, di, bus.oHRDATA, xrd); end
          checks++; if (pcyc != (hit ? acc + 1 : 0)) begin errors++; $display("FAIL %s[%0d] psel cycles got=%0d exp=%0d", name, di, pcyc, hit ? acc + 1 : 0); end
          checks++; if (ecyc != (hit ? acc : 0)) begin errors++; $display("FAIL %s[%0d] penable cycles got=%0d exp=%0d", name, di, ecyc, hit ? acc : 0); end
          checks++; if (rcyc != (xerr ? 2 : 0)) begin errors++; $display("FAIL %s[%0d] error cycles got=%0d exp=%0d", name, di, rcyc, xerr ? 2 : 0); end
          if (xerr) begin
            checks++; if (prev_resp !== 2'b01 || prev_hro !== 1'b0) begin errors++; $display("FAIL %s[%0d] first error cycle got resp=%b hready=%b exp resp=01 hready=0", name, di, prev_resp, prev_hro); end
          end
          if (hit && !xerr && t.wr) ref_mem[idx] = t.wdata;
          done++;
        end
        @(posedge clk); #1;
        di = ap_v ? ap : -1;
        dcyc = 0; pcyc = 0; ecyc = 0; rcyc = 0;
        if (di >= 0) begin
          t = seq_q[di];
          bus.iHWDATA = t.wdata; cfg_wait = t.waits; cfg_err = t.err;
          idx  = int'(t.addr >> 15);
          hit  = (t.addr >> 15) < NS;
          acc  = (t.waits >= TO) ? TO : t.waits + 1;
          xerr = !hit || (t.waits >= TO) || t.err;
          xsel = hit ? (4'b0001 << idx) : 4'b0000;
          xcyc = !hit ? 2 : (t.wr ? 1 : 0) + 1 + acc + (xerr ? 2 : 0);
        end
        if (ai < n) begin present(ai); ap = ai; ap_v = 1'b1; ai++; end
        else begin idle_bus(); ap_v = 1'b0; end
      end
      prev_hro = hro; prev_resp = resp;
    end
    checks++;
    if (done < n) begin
      errors++;
      $display("FAIL %s completion: got=%0d transfers exp=%0d within cycle budget", name, done, n);
      apply_reset();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_read_slave1();
    seq_q = {};
    seq_q.push_back(mk(32'h0000_8004, 1'b0, 32'h0, 0, 1'b0));
    run_seq("read_slave1");
  endtask

  task automatic test_write_wait();
    seq_q = {};
    seq_q.push_back(mk(32'h0001_0000, 1'b1, 32'h1234_5678, 3, 1'b0));
    seq_q.push_back(mk(32'h0001_0010, 1'b0, 32'h0, 1, 1'b0));
    run_seq("write_wait");
  endtask

  task automatic test_decode_miss();
    seq_q = {};
    seq_q.push_back(mk(32'h0002_0000, 1'b0, 32'h0, 0, 1'b0));
    seq_q.push_back(mk(32'hFFFF_0000, 1'b1, 32'hCAFE_F00D, 0, 1'b0));
    seq_q.push_back(mk(32'h0000_0008, 1'b0, 32'h0, 0, 1'b0));
    run_seq("decode_miss");
  endtask

  task automatic test_pslverr();
    seq_q = {};
    seq_q.push_back(mk(32'h0000_0000, 1'b0, 32'h0, 0, 1'b1));
    seq_q.push_back(mk(32'h0000_8000, 1'b0, 32'h0, 0, 1'b0));
    seq_q.push_back(mk(32'h0000_0004, 1'b1, 32'h0BAD_0BAD, 1, 1'b1));
    seq_q.push_back(mk(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0));
    run_seq("pslverr");
  endtask

  task automatic test_timeout();
    seq_q = {};
    seq_q.push_back(mk(32'h0001_8000, 1'b0, 32'h0, 50, 1'b0));
    seq_q.push_back(mk(32'h0001_8000, 1'b1, 32'h7777_0000, 50, 1'b0));
    seq_q.push_back(mk(32'h0001_8000, 1'b0, 32'h0, 0, 1'b0));
    run_seq("timeout");
  endtask

  task automatic test_back_to_back();
    seq_q = {};
    for (int k = 0; k < NS; k++) seq_q.push_back(mk(32'(k) << 15, 1'b0, 32'h0, 0, 1'b0));
    run_seq("back_to_back");
  endtask

  task automatic test_idle_busy();
    logic [1:0] tr [2];
    tr[0] = 2'b01; tr[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.iHSEL = 1'b1; bus.iHTRANS = tr[i]; bus.iHWRITE = 1'b1; bus.iHADDR = 32'h0000_8000;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++; if (bus.oHREADYOUT !== 1'b1 || bus.oHRESP !== 2'b00) begin errors++; $display("FAIL idle_busy htrans=%b hready=%b hresp=%b exp hready=1 hresp=00", tr[i], bus.oHREADYOUT, bus.oHRESP); end
        checks++; if (bus.oPSEL !== 4'b0000 || bus.oPENABLE !== 1'b0) begin errors++; $display("FAIL idle_busy htrans=%b psel=%b penable=%b exp 0000/0", tr[i], bus.oPSEL, bus.oPENABLE); end
      end
    end
    @(posedge clk); #1 idle_bus();
  endtask

  task automatic test_random();
    txn_t t;
    int kind;
    seq_q = {};
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 5));
      if (kind < 4) t.addr = (32'(kind) << 15) | (32'($urandom_range(0, 8191)) << 2);
      else if (kind == 4) t.addr = 32'h0002_0000 | (32'($urandom_range(0, 8191)) << 2);
      else t.addr = $urandom | 32'h8000_0000;
      t.wr    = bit'($urandom_range(0, 1));
      t.wdata = $urandom;
      t.waits = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
      t.err   = ($urandom_range(0, 5) == 0);
      t.trans = (i == 0 || $urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      seq_q.push_back(t);
    end
    run_seq("random");
  endtask

  task automatic test_reset_mid();
    int guard;
    @(posedge clk); #1;
    bus.iHSEL = 1'b1; bus.iHTRANS = 2'b10; bus.iHWRITE = 1'b1; bus.iHADDR = 32'h0001_8010;
    cfg_wait = 50; cfg_err = 1'b0;
    @(posedge clk); #1;
    bus.iHWDATA = 32'hDEAD_BEEF; idle_bus();
    guard = 0;
    @(negedge clk);
    while (bus.oPENABLE !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    checks++; if (bus.oPENABLE !== 1'b1 || bus.oPSEL !== 4'b1000) begin errors++; $display("FAIL reset_mid access reached psel=%b penable=%b exp 1000/1", bus.oPSEL, bus.oPENABLE); end
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset_mid");
    apply_reset();
    @(negedge clk);
    checks++; if (bus.oPSEL !== 4'b0000) begin errors++; $display("FAIL reset_mid after release psel=%b exp=0000", bus.oPSEL); end
  endtask

  initial begin
    idle_bus();
    bus.iHWDATA = 32'h0;
    test_reset();
    test_read_slave1();
    test_write_wait();
    test_decode_miss();
    test_pslverr();
    test_timeout();
    test_back_to_back();
    test_idle_busy();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
